// File: rtl/prefix_scan_seq.sv
// Sequential x86 legacy-prefix scanner: accumulates prefix bytes from the fetch
// stream and emits one record per instruction when the opcode byte arrives.
module prefix_scan_seq #(
  parameter int MAX_PREFIX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_seg,
  output logic             out_seg_valid,
  output logic [1:0]       out_rep,
  output logic             out_size,
  output logic             out_lock,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_err,
  output logic [7:0]       out_opcode
);

  localparam logic [0:0] SCAN = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREFIX);

  logic [0:0]       state, state_nxt;
  logic             accept, retire;

  logic             byte_is_prefix, byte_is_seg;
  logic [2:0]       byte_seg;

  logic [2:0]       seg_base, seg_nxt;
  logic             seg_valid_base, seg_valid_nxt;
  logic [1:0]       rep_base, rep_nxt;
  logic             size_base, size_nxt;
  logic             lock_base, lock_nxt;
  logic [CNT_W-1:0] cnt_base, cnt_nxt;
  logic             err_nxt;
  logic [7:0]       opcode_nxt;

  assign out_valid = (state == HOLD);

  always_comb begin
    in_ready = !flush && ((state == SCAN) || ((state == HOLD) && out_ready));
    accept   = in_valid && in_ready;
    retire   = (state == HOLD) && out_ready;
  end

  always_comb begin
    byte_is_prefix = 1'b1;
    byte_is_seg    = 1'b0;
    byte_seg       = 3'd0;
    case (in_byte)
      8'h26: begin byte_is_seg = 1'b1; byte_seg = 3'd0; end
      8'h2E: begin byte_is_seg = 1'b1; byte_seg = 3'd1; end
      8'h36: begin byte_is_seg = 1'b1; byte_seg = 3'd2; end
      8'h3E: begin byte_is_seg = 1'b1; byte_seg = 3'd3; end
      8'h64: begin byte_is_seg = 1'b1; byte_seg = 3'd4; end
      8'h65: begin byte_is_seg = 1'b1; byte_seg = 3'd5; end
      8'hF0, 8'hF2, 8'hF3, 8'h66: byte_is_prefix = 1'b1;
      default: byte_is_prefix = 1'b0;
    endcase
  end

  // A retiring record clears the accumulators before the byte accepted in the
  // same cycle is applied, so back-to-back records need no bubble.
  always_comb begin
    if (retire) begin
      seg_base       = 3'd0;
      seg_valid_base = 1'b0;
      rep_base       = 2'd0;
      size_base      = 1'b0;
      lock_base      = 1'b0;
      cnt_base       = '0;
      state_nxt      = SCAN;
    end else begin
      seg_base       = out_seg;
      seg_valid_base = out_seg_valid;
      rep_base       = out_rep;
      size_base      = out_size;
      lock_base      = out_lock;
      cnt_base       = out_cnt;
      state_nxt      = state;
    end

    seg_nxt       = seg_base;
    seg_valid_nxt = seg_valid_base;
    rep_nxt       = rep_base;
    size_nxt      = size_base;
    lock_nxt      = lock_base;
    cnt_nxt       = cnt_base;
    err_nxt       = out_err;
    opcode_nxt    = out_opcode;

    if (accept) begin
      if (byte_is_prefix && (cnt_base < CNT_MAX)) begin
        cnt_nxt = cnt_base + CNT_W'(1);
        if (byte_is_seg) begin
          seg_nxt       = byte_seg;
          seg_valid_nxt = 1'b1;
        end
        if (in_byte == 8'hF3) rep_nxt  = 2'd1;
        if (in_byte == 8'hF2) rep_nxt  = 2'd2;
        if (in_byte == 8'h66) size_nxt = 1'b1;
        if (in_byte == 8'hF0) lock_nxt = 1'b1;
      end else begin
        // A prefix arriving with the count already full ends the record as an error.
        err_nxt    = byte_is_prefix;
        opcode_nxt = in_byte;
        state_nxt  = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state         <= SCAN;
      out_seg       <= 3'd0;
      out_seg_valid <= 1'b0;
      out_rep       <= 2'd0;
      out_size      <= 1'b0;
      out_lock      <= 1'b0;
      out_cnt       <= '0;
      out_err       <= 1'b0;
      out_opcode    <= 8'd0;
    end else begin
      state         <= state_nxt;
      out_seg       <= seg_nxt;
      out_seg_valid <= seg_valid_nxt;
      out_rep       <= rep_nxt;
      out_size      <= size_nxt;
      out_lock      <= lock_nxt;
      out_cnt       <= cnt_nxt;
      out_err       <= err_nxt;
      out_opcode    <= opcode_nxt;
    end
  end

endmodule
